// File: rtl/data_path.sv
// Single-bus datapath: sixteen general registers, PC/IR/MAR/MDR, Y/Z around a 64-bit ALU, HI/LO.
// The internal bus is a priority mux; every register loads from it (MDR may also take memory data).
module data_path (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        HIin,
    input  logic        HIout,
    input  logic        LOin,
    input  logic        LOout,
    input  logic        PCin,
    input  logic        PCout,
    input  logic        IRin,
    input  logic        Zin,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        Yin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        MDRout,
    input  logic        Read,
    input  logic [31:0] Mdatain,
    input  logic        R0out,
    input  logic        R1out,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        R8out,
    input  logic        R9out,
    input  logic        R10out,
    input  logic        R11out,
    input  logic        R12out,
    input  logic        R13out,
    input  logic        R14out,
    input  logic        R15out,
    input  logic        R0in,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        ADD,
    input  logic        SUB,
    input  logic        SHR,
    input  logic        SHRA,
    input  logic        SHL,
    input  logic        ROR,
    input  logic        ROL,
    input  logic        AND,
    input  logic        OR,
    input  logic        MUL,
    input  logic        DIV,
    input  logic        NEG,
    input  logic        NOT,
    output logic [31:0] BusMuxOut
);

    logic [15:0]        r_out_s;
    logic [15:0]        r_in_s;
    logic [31:0]        r_r [16];
    logic [31:0]        pc_r;
    logic [31:0]        ir_r;
    logic [31:0]        mar_r;
    logic [31:0]        mdr_r;
    logic [31:0]        y_r;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;
    logic [63:0]        z_r;
    logic [31:0]        bus_s;
    logic [63:0]        alu_s;
    logic [4:0]         shamt_s;
    logic signed [63:0] mul_s;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic               unused_ok_s;

    assign r_out_s = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign r_in_s  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

    // IR and MAR feed blocks outside this datapath; fold them here so they are not flagged as dead.
    assign unused_ok_s = ^{ir_r, mar_r};

    // Lowest-numbered asserted general-register select wins the bus.
    function automatic logic [3:0] low_index(input logic [15:0] sel);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (sel[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Bus priority mux; idle bus reads as zero.
    always_comb begin
        bus_s = 32'd0;
        if (|r_out_s) begin
            bus_s = r_r[low_index(r_out_s)];
        end else if (HIout) begin
            bus_s = hi_r;
        end else if (LOout) begin
            bus_s = lo_r;
        end else if (Zhighout) begin
            bus_s = z_r[63:32];
        end else if (Zlowout) begin
            bus_s = z_r[31:0];
        end else if (PCout) begin
            bus_s = pc_r;
        end else if (MDRout) begin
            bus_s = mdr_r;
        end else begin
            bus_s = 32'd0;
        end
    end

    assign BusMuxOut = bus_s;
    assign shamt_s   = bus_s[4:0];
    assign mul_s     = $signed({{32{y_r[31]}}, y_r}) * $signed({{32{bus_s[31]}}, bus_s});
    // Divide by zero is guarded so the divider never sees a zero divisor.
    assign quot_s    = (bus_s == 32'd0) ? 32'sd0 : ($signed(y_r) / $signed(bus_s));
    assign rem_s     = (bus_s == 32'd0) ? 32'sd0 : ($signed(y_r) % $signed(bus_s));

    // ALU: A = Y, B = bus; first asserted op in priority order selects the result.
    always_comb begin
        alu_s = 64'd0;
        if (ADD) begin
            alu_s = {32'd0, y_r + bus_s};
        end else if (SUB) begin
            alu_s = {32'd0, y_r - bus_s};
        end else if (SHR) begin
            alu_s = {32'd0, y_r >> shamt_s};
        end else if (SHRA) begin
            alu_s = {32'd0, $signed(y_r) >>> shamt_s};
        end else if (SHL) begin
            alu_s = {32'd0, y_r << shamt_s};
        end else if (ROR) begin
            alu_s = {32'd0, (y_r >> shamt_s) | (y_r << (6'd32 - {1'b0, shamt_s}))};
        end else if (ROL) begin
            alu_s = {32'd0, (y_r << shamt_s) | (y_r >> (6'd32 - {1'b0, shamt_s}))};
        end else if (AND) begin
            alu_s = {32'd0, y_r & bus_s};
        end else if (OR) begin
            alu_s = {32'd0, y_r | bus_s};
        end else if (MUL) begin
            alu_s = mul_s;
        end else if (DIV) begin
            if (bus_s == 32'd0) begin
                alu_s = {y_r, 32'd0};
            end else begin
                alu_s = {rem_s, quot_s};
            end
        end else if (NEG) begin
            alu_s = {32'd0, 32'd0 - bus_s};
        end else if (NOT) begin
            alu_s = {32'd0, ~bus_s};
        end else begin
            alu_s = {32'd0, bus_s + 32'd1};
        end
    end

    // Register set: Clear wins over every load; a load in the same cycle as a drive takes the pre-edge value.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < 16; i++) begin
                r_r[i] <= 32'd0;
            end
            pc_r  <= 32'd0;
            ir_r  <= 32'd0;
            mar_r <= 32'd0;
            mdr_r <= 32'd0;
            y_r   <= 32'd0;
            hi_r  <= 32'd0;
            lo_r  <= 32'd0;
            z_r   <= 64'd0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (r_in_s[i]) begin
                    r_r[i] <= bus_s;
                end
            end
            if (PCin)  pc_r  <= bus_s;
            if (IRin)  ir_r  <= bus_s;
            if (MARin) mar_r <= bus_s;
            if (MDRin) mdr_r <= Read ? Mdatain : bus_s;
            if (Yin)   y_r   <= bus_s;
            if (HIin)  hi_r  <= bus_s;
            if (LOin)  lo_r  <= bus_s;
            if (Zin)   z_r   <= alu_s;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed datapath sequences followed by random control words,
// with every bus value compared against an arithmetic model of the register set.
module tb_data_path;

    logic        clock;
    logic        clear;
    logic [15:0] rin;
    logic [15:0] rout;
    logic        hi_in, hi_out, lo_in, lo_out, pc_in, pc_out, ir_in, z_in;
    logic        zhi_out, zlo_out, y_in, mar_in, mdr_in, mdr_out, rd;
    logic [31:0] mdata;
    logic [12:0] op;
    logic [31:0] bus;

    int total;
    int bad;

    logic [31:0] mr [16];
    logic [31:0] mpc, mmdr, my, mhi, mlo;
    logic [63:0] mz;

    data_path dut (
        .Clock(clock), .Clear(clear), .HIin(hi_in), .HIout(hi_out), .LOin(lo_in), .LOout(lo_out),
        .PCin(pc_in), .PCout(pc_out), .IRin(ir_in), .Zin(z_in), .Zhighout(zhi_out), .Zlowout(zlo_out),
        .Yin(y_in), .MARin(mar_in), .MDRin(mdr_in), .MDRout(mdr_out), .Read(rd), .Mdatain(mdata),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .ADD(op[0]), .SUB(op[1]), .SHR(op[2]), .SHRA(op[3]), .SHL(op[4]), .ROR(op[5]), .ROL(op[6]),
        .AND(op[7]), .OR(op[8]), .MUL(op[9]), .DIV(op[10]), .NEG(op[11]), .NOT(op[12]),
        .BusMuxOut(bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        clear = 1'b0; rin = 16'd0; rout = 16'd0; op = 13'd0;
        hi_in = 1'b0; hi_out = 1'b0; lo_in = 1'b0; lo_out = 1'b0; pc_in = 1'b0; pc_out = 1'b0;
        ir_in = 1'b0; z_in = 1'b0; zhi_out = 1'b0; zlo_out = 1'b0; y_in = 1'b0; mar_in = 1'b0;
        mdr_in = 1'b0; mdr_out = 1'b0; rd = 1'b0;
    endtask

    function automatic logic [31:0] model_bus();
        for (int i = 0; i < 16; i++) if (rout[i]) return mr[i];
        if (hi_out)  return mhi;
        if (lo_out)  return mlo;
        if (zhi_out) return mz[63:32];
        if (zlo_out) return mz[31:0];
        if (pc_out)  return mpc;
        if (mdr_out) return mmdr;
        return 32'd0;
    endfunction

    function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [12:0] ops);
        int k;
        int n;
        longint sa, sb, q, r;
        logic [31:0] t;
        k = 13;
        for (int i = 12; i >= 0; i--) if (ops[i]) k = i;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n = int'(b[4:0]);
        t = a;
        case (k)
            0: return {32'd0, a + b};
            1: return {32'd0, a - b};
            2: return {32'd0, a >> n};
            3: return {32'd0, 32'(sa >>> n)};
            4: return {32'd0, a << n};
            5: begin repeat (n) t = {t[0], t[31:1]}; return {32'd0, t}; end
            6: begin repeat (n) t = {t[30:0], t[31]}; return {32'd0, t}; end
            7: return {32'd0, a & b};
            8: return {32'd0, a | b};
            9: return sa * sb;
            10: begin
                if (b == 32'd0) return {a, 32'd0};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            11: return {32'd0, 32'd0 - b};
            12: return {32'd0, ~b};
            default: return {32'd0, b + 32'd1};
        endcase
    endfunction

    // One clock: check the bus against the model, then advance the model and the DUT together.
    task automatic step();
        logic [31:0] b;
        logic [63:0] zn;
        #1;
        b = model_bus();
        check_eq("bus", {32'd0, bus}, {32'd0, b});
        zn = model_alu(my, b, op);
        if (clear) begin
            for (int i = 0; i < 16; i++) mr[i] = 32'd0;
            mpc = 32'd0; mmdr = 32'd0; my = 32'd0; mhi = 32'd0; mlo = 32'd0; mz = 64'd0;
        end else begin
            for (int i = 0; i < 16; i++) if (rin[i]) mr[i] = b;
            if (pc_in)  mpc = b;
            if (mdr_in) mmdr = rd ? mdata : b;
            if (y_in)   my = b;
            if (hi_in)  mhi = b;
            if (lo_in)  mlo = b;
            if (z_in)   mz = zn;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic peek(input string tag, input logic [31:0] exp);
        #1;
        check_eq(tag, {32'd0, bus}, {32'd0, exp});
    endtask

    task automatic load_reg(input int idx, input logic [31:0] val);
        idle(); mdata = val; rd = 1'b1; mdr_in = 1'b1; step();
        idle(); mdr_out = 1'b1; rin[idx] = 1'b1; step();
        idle(); rout[idx] = 1'b1; peek("load", val);
    endtask

    task automatic alu_op(input int ya, input int bb, input int opbit);
        idle(); rout[ya] = 1'b1; y_in = 1'b1; step();
        idle(); rout[bb] = 1'b1; op[opbit] = 1'b1; z_in = 1'b1; step();
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            idle(); rout[i] = 1'b1; peek(tag, 32'd0);
        end
        idle(); hi_out = 1'b1;  peek(tag, 32'd0);
        idle(); lo_out = 1'b1;  peek(tag, 32'd0);
        idle(); zhi_out = 1'b1; peek(tag, 32'd0);
        idle(); zlo_out = 1'b1; peek(tag, 32'd0);
        idle(); pc_out = 1'b1;  peek(tag, 32'd0);
        idle(); mdr_out = 1'b1; peek(tag, 32'd0);
    endtask

    initial begin
        int n;
        int s;
        total = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) mr[i] = 32'd0;
        mpc = 32'd0; mmdr = 32'd0; my = 32'd0; mhi = 32'd0; mlo = 32'd0; mz = 64'd0;
        idle();
        mdata = 32'd0;
        @(negedge clock);
        clear = 1'b1;
        step();
        check_all_zero("reset");

        load_reg(2, 32'h8000_0012);
        load_reg(3, 32'h0000_0004);
        load_reg(1, 32'h0000_0018);

        alu_op(2, 3, 2);
        idle(); zlo_out = 1'b1; rin[1] = 1'b1; step();
        idle(); rout[1] = 1'b1; peek("shr", 32'h0800_0001);

        idle(); pc_out = 1'b1; mar_in = 1'b1; z_in = 1'b1; step();
        idle(); zlo_out = 1'b1; peek("pc_inc", 32'h0000_0001);
        pc_in = 1'b1; rd = 1'b1; mdr_in = 1'b1; mdata = 32'h1486_0000; step();
        idle(); pc_out = 1'b1; peek("pc", 32'h0000_0001);
        idle(); mdr_out = 1'b1; ir_in = 1'b1; peek("mdr_ir", 32'h1486_0000); step();

        load_reg(4, 32'hFFFF_FFFE);
        load_reg(5, 32'h0000_0003);
        alu_op(4, 5, 9);
        idle(); zhi_out = 1'b1; peek("mul_hi", 32'hFFFF_FFFF); hi_in = 1'b1; step();
        idle(); zlo_out = 1'b1; peek("mul_lo", 32'hFFFF_FFFA); lo_in = 1'b1; step();
        idle(); hi_out = 1'b1; peek("hi", 32'hFFFF_FFFF);
        idle(); lo_out = 1'b1; peek("lo", 32'hFFFF_FFFA);

        load_reg(6, 32'hFFFF_FFF9);
        load_reg(7, 32'h0000_0002);
        alu_op(6, 7, 10);
        idle(); zlo_out = 1'b1; peek("div_q", 32'hFFFF_FFFD);
        idle(); zhi_out = 1'b1; peek("div_r", 32'hFFFF_FFFF);
        load_reg(8, 32'h0000_0005);
        load_reg(9, 32'h0000_0000);
        alu_op(8, 9, 10);
        idle(); zlo_out = 1'b1; peek("div0_q", 32'h0000_0000);
        idle(); zhi_out = 1'b1; peek("div0_r", 32'h0000_0005);

        idle(); rout[1] = 1'b1; rout[2] = 1'b1; hi_out = 1'b1; peek("bus_prio", 32'h0800_0001);
        idle(); rout[1] = 1'b1; rin[1] = 1'b1; step();
        idle(); rout[1] = 1'b1; peek("self_load", 32'h0800_0001);

        idle(); rout[2] = 1'b1; rin[1] = 1'b1; clear = 1'b1; step();
        check_all_zero("clear");

        for (int c = 0; c < 400; c++) begin
            idle();
            n = int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++) begin
                s = int'($urandom_range(0, 21));
                case (s)
                    16: hi_out = 1'b1;
                    17: lo_out = 1'b1;
                    18: zhi_out = 1'b1;
                    19: zlo_out = 1'b1;
                    20: pc_out = 1'b1;
                    21: mdr_out = 1'b1;
                    default: rout[s] = 1'b1;
                endcase
            end
            rin = 16'($urandom & $urandom & $urandom);
            hi_in = ($urandom_range(0, 3) == 0); lo_in = ($urandom_range(0, 3) == 0);
            pc_in = ($urandom_range(0, 3) == 0); ir_in = ($urandom_range(0, 3) == 0);
            z_in = ($urandom_range(0, 1) == 0);  y_in = ($urandom_range(0, 2) == 0);
            mar_in = ($urandom_range(0, 3) == 0); mdr_in = ($urandom_range(0, 1) == 0);
            rd = ($urandom_range(0, 1) == 0);
            s = int'($urandom_range(0, 15));
            if (s < 13) op[s] = 1'b1;
            if ($urandom_range(0, 4) == 0) op[$urandom_range(0, 12)] = 1'b1;
            mdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            clear = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: DataPath

Interface
REQ-001 Port order SHALL be Clock, Clear, HIin, HIout, LOin, LOout, PCin, PCout, IRin, Zin, Zhighout, Zlowout, Yin, MARin, MDRin, MDRout, Read, Mdatain, R0out..R15out, R0in..R15in, ADD, SUB, SHR, SHRA, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT, BusMuxOut.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Clear  input  1  reset; synchronous, active-high.
REQ-004 R0in..R15in, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin  input  1 each  register load enables.
REQ-005 R0out..R15out, PCout, MDRout, HIout, LOout, Zhighout, Zlowout  input  1 each  bus drive selects.
REQ-006 Read  input  1  MDR source select: 1 = Mdatain, 0 = bus.
REQ-007 Mdatain  input  32  memory data in.
REQ-008 ADD, SUB, SHR, SHRA, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT  input  1 each  ALU op selects.
REQ-009 BusMuxOut  output  32  current internal bus value, for observation.

Function
REQ-010 Registers SHALL be: R0-R15, PC, IR, MAR, MDR, Y, HI, LO (32 bits each) and Z (64 bits, split ZHI/ZLO).
REQ-011 A register SHALL load on a rising edge when its enable is 1; otherwise it SHALL hold.
REQ-012 R0-R15, PC, IR, MAR, Y, HI and LO SHALL load from the bus.
REQ-013 MDR SHALL load Mdatain when Read=1 and the bus when Read=0.
REQ-014 Bus SHALL be combinational. Priority when several selects are 1: R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout. No select asserted -> bus = 0.
REQ-015 ALU operand A SHALL be Y and operand B SHALL be the bus. The ALU result SHALL be 64 bits and SHALL load into Z when Zin=1.
REQ-016 ADD/SUB/AND/OR SHALL produce ZLO = A op B, modulo 2^32, with ZHI = 0.
REQ-017 Shifts and rotates SHALL use amount = B[4:0]:
  - SHR: logical right shift.
  - SHRA: arithmetic right shift.
  - SHL: logical left shift.
  - ROR, ROL: 32-bit rotate.
  - ZHI = 0 for all of these.
REQ-018 NEG SHALL give ZLO = -B and NOT SHALL give ZLO = ~B; both ignore Y and set ZHI = 0.
REQ-019 MUL SHALL give Z = signed A * signed B, full 64 bits.
REQ-020 DIV SHALL be signed, giving ZLO = quotient (truncated toward zero) and ZHI = remainder (sign follows dividend).
REQ-021 DIV with B = 0 SHALL give ZLO = 0 and ZHI = A.
REQ-022 No op select asserted SHALL give ZLO = B + 1 and ZHI = 0; this is the PC-increment path.
REQ-023 If several op selects are 1, priority SHALL be ADD, SUB, SHR, SHRA, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT.
REQ-024 Zhighout SHALL drive ZHI onto the bus and Zlowout SHALL drive ZLO.
REQ-025 Load and drive in the same cycle (e.g. R1out + R1in) SHALL load the pre-edge value unchanged.

Reset
REQ-026 While Clear=1 at a rising edge, all registers, including Z, SHALL become 0, overriding every load enable.
REQ-027 Clear mid-sequence SHALL zero all state; the operation in flight SHALL be lost.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
  - Loads: Mdatain=0x80000012 with Read+MDRin, then MDRout+R2in -> R2 = 0x80000012. Same for R3 = 4 and R1 = 0x18.
  - SHR: R2out+Yin, then R3out+SHR+Zin, then Zlowout+R1in -> R1 = 0x08000001.
  - Fetch from PC=0: PCout+MARin+Zin with no op -> MAR = 0, ZLO = 1. Then Zlowout+PCin plus Read+MDRin with Mdatain=0x14860000 -> PC = 1. Then MDRout+IRin -> IR = 0x14860000.
  - MUL: Y = 0xFFFFFFFE (-2), B = 3 -> Z = 0xFFFFFFFF_FFFFFFFA. Zhighout+HIin and Zlowout+LOin load HI and LO accordingly.
  - DIV: Y = -7, B = 2 -> ZLO = 0xFFFFFFFD, ZHI = 0xFFFFFFFF. Y = 5, B = 0 -> ZLO = 0, ZHI = 5.
  - Clear: Clear=1 for one edge while R1in=1 and the bus is nonzero -> R1 = 0, and all other registers read 0.
